// File: rtl/expr_sweep_ctrl_pkg.sv
// Shared types and constants for the expression-evaluator sweep controller.
package expr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

  localparam int unsigned NVEC  = 16;
  localparam int unsigned VEC_W = 4;
  localparam int unsigned ERR_W = 5;
  localparam logic [NVEC-1:0] GOLDEN_TT_DEFAULT = 16'h3887;

endpackage

// File: rtl/expr_sweep_ctrl_if.sv
// Request, evaluator and result signals of the sweep controller.
// The master side is the controller; the slave side is the requester plus evaluator.
interface expr_sweep_ctrl_if;
  import expr_pkg::*;

  logic                start;
  logic                abort;
  logic                nand_i;
  logic                nor_i;
  logic [VEC_W-1:0]    vec_o;
  logic                busy;
  logic                done;
  logic                result_valid;
  logic [NVEC-1:0]     tt_nand;
  logic [NVEC-1:0]     tt_nor;
  logic [NVEC-1:0]     mismatch_mask;
  logic [ERR_W-1:0]    err_cnt;
  logic                pass;

  modport master (
    input  start, abort, nand_i, nor_i,
    output vec_o, busy, done, result_valid, tt_nand, tt_nor,
           mismatch_mask, err_cnt, pass
  );

  modport slave (
    output start, abort, nand_i, nor_i,
    input  vec_o, busy, done, result_valid, tt_nand, tt_nor,
           mismatch_mask, err_cnt, pass
  );

endinterface

// File: rtl/expr_sweep_ctrl.sv
// Built-in self-test sequencer: walks all 16 input vectors through the
// NAND-form and NOR-form evaluators, samples both outputs after a settle
// delay and grades them against the golden truth table.
module expr_sweep_ctrl
  import expr_pkg::*;
#(
  parameter int unsigned     SETTLE_CYCLES = 0,
  parameter logic [NVEC-1:0] GOLDEN_TT     = GOLDEN_TT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  expr_sweep_ctrl_if.master  bus
);

  localparam logic [3:0]       SETTLE_L = 4'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0] VEC_LAST = 4'd15;

  sweep_state_t     r_state, w_state_nxt;
  logic [VEC_W-1:0] r_vec, w_vec_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [NVEC-1:0]  r_tt_nand, w_tt_nand_nxt;
  logic [NVEC-1:0]  r_tt_nor, w_tt_nor_nxt;
  logic [NVEC-1:0]  r_mask, w_mask_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_pass, w_pass_nxt;
  logic             w_miss;

  // Mismatch of either evaluator form against the golden bit of the current vector.
  always_comb begin
    w_miss = (bus.nand_i != GOLDEN_TT[r_vec]) || (bus.nor_i != GOLDEN_TT[r_vec]);
  end

  // Next-state and next-output logic; abort takes priority over a sample edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_vec_nxt     = r_vec;
    w_cnt_nxt     = r_cnt;
    w_tt_nand_nxt = r_tt_nand;
    w_tt_nor_nxt  = r_tt_nor;
    w_mask_nxt    = r_mask;
    w_err_nxt     = r_err;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_valid_nxt   = r_valid;
    w_pass_nxt    = r_pass;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt   = DRIVE;
          w_vec_nxt     = 4'd0;
          w_cnt_nxt     = 4'd0;
          w_tt_nand_nxt = 16'h0000;
          w_tt_nor_nxt  = 16'h0000;
          w_mask_nxt    = 16'h0000;
          w_err_nxt     = 5'd0;
          w_valid_nxt   = 1'b0;
          w_pass_nxt    = 1'b0;
          w_busy_nxt    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == SETTLE_L) begin
          w_cnt_nxt              = 4'd0;
          w_tt_nand_nxt[r_vec]   = bus.nand_i;
          w_tt_nor_nxt[r_vec]    = bus.nor_i;
          if (w_miss) begin
            w_mask_nxt[r_vec] = 1'b1;
            w_err_nxt         = r_err + 5'd1;
          end else begin
            w_err_nxt = r_err;
          end
          if (r_vec == VEC_LAST) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
            w_pass_nxt  = (w_err_nxt == 5'd0);
          end else begin
            w_vec_nxt  = r_vec + 4'd1;
            w_busy_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt  = r_cnt + 4'd1;
          w_busy_nxt = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_vec     <= 4'd0;
      r_cnt     <= 4'd0;
      r_tt_nand <= 16'h0000;
      r_tt_nor  <= 16'h0000;
      r_mask    <= 16'h0000;
      r_err     <= 5'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vec     <= w_vec_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tt_nand <= w_tt_nand_nxt;
      r_tt_nor  <= w_tt_nor_nxt;
      r_mask    <= w_mask_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_valid   <= w_valid_nxt;
      r_pass    <= w_pass_nxt;
    end
  end

  assign bus.vec_o         = r_vec;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.result_valid  = r_valid;
  assign bus.tt_nand       = r_tt_nand;
  assign bus.tt_nor        = r_tt_nor;
  assign bus.mismatch_mask = r_mask;
  assign bus.err_cnt       = r_err;
  assign bus.pass          = r_pass;

endmodule

// File: tb/tb_expr_sweep_ctrl.sv
// Directed bench for expr_sweep_ctrl: one instance with no settle delay and
// one with a 3-cycle settle delay, each driven by a behavioural evaluator.
module tb_expr_sweep_ctrl;
  import expr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad = 0;
  logic        flip_nand3 = 1'b0;
  logic        nor_stuck0 = 1'b0;
  logic [15:0] gold = 16'h3887;

  expr_sweep_ctrl_if if0 ();
  expr_sweep_ctrl_if if3 ();

  expr_sweep_ctrl #(.SETTLE_CYCLES(0), .GOLDEN_TT(16'h3887)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  expr_sweep_ctrl #(.SETTLE_CYCLES(3), .GOLDEN_TT(16'h3887)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3)
  );

  always #5 clk = ~clk;

  // Behavioural evaluators with optional fault injection on instance 0.
  assign if0.nand_i = gold[if0.vec_o] ^ (flip_nand3 & (if0.vec_o == 4'd3));
  assign if0.nor_i  = gold[if0.vec_o] & ~nor_stuck0;
  assign if3.nand_i = gold[if3.vec_o];
  assign if3.nor_i  = gold[if3.vec_o];

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) if0.start = 1'b1; else if3.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    if3.start = 1'b0;
  endtask

  task automatic run_to_done(input int sel, input int budget, output int cyc);
    cyc = 0;
    while (((sel == 0) ? if0.done : if3.done) !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if0.start = 1'b1; if3.start = 1'b1; if0.abort = 1'b0; if3.abort = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({if0.vec_o, if0.busy, if0.done, if0.result_valid, if0.tt_nand, if0.tt_nor,
         if0.mismatch_mask, if0.err_cnt, if0.pass} !== 60'd0) begin
      bad++; $display("FAIL reset_dut0 got vec=%h busy=%b tt_nand=%h mask=%h err=%0d expected all zero",
                      if0.vec_o, if0.busy, if0.tt_nand, if0.mismatch_mask, if0.err_cnt);
    end
    total++;
    if ({if3.vec_o, if3.busy, if3.done, if3.result_valid, if3.tt_nand, if3.tt_nor,
         if3.mismatch_mask, if3.err_cnt, if3.pass} !== 60'd0) begin
      bad++; $display("FAIL reset_dut3 got vec=%h busy=%b tt_nand=%h mask=%h err=%0d expected all zero",
                      if3.vec_o, if3.busy, if3.tt_nand, if3.mismatch_mask, if3.err_cnt);
    end
    if0.start = 1'b0; if3.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (if0.busy !== 1'b0 || if3.busy !== 1'b0) begin
      bad++; $display("FAIL reset_release got busy0=%b busy3=%b expected 0 0", if0.busy, if3.busy);
    end
  endtask

  task automatic test_healthy();
    pulse_start(0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (if0.vec_o !== 4'(k) || if0.busy !== 1'b1 || if0.done !== 1'b0) begin
        bad++; $display("FAIL healthy_step got vec=%0d busy=%b done=%b expected vec=%0d busy=1 done=0",
                        if0.vec_o, if0.busy, if0.done, k);
      end
      @(negedge clk);
    end
    total++;
    if (if0.done !== 1'b1 || if0.busy !== 1'b0 || if0.result_valid !== 1'b1) begin
      bad++; $display("FAIL healthy_done got done=%b busy=%b valid=%b expected 1 0 1",
                      if0.done, if0.busy, if0.result_valid);
    end
    total++;
    if (if0.tt_nand !== 16'h3887 || if0.tt_nor !== 16'h3887) begin
      bad++; $display("FAIL healthy_tt got nand=%h nor=%h expected 3887 3887", if0.tt_nand, if0.tt_nor);
    end
    total++;
    if (if0.mismatch_mask !== 16'h0000 || if0.err_cnt !== 5'd0 || if0.pass !== 1'b1) begin
      bad++; $display("FAIL healthy_grade got mask=%h err=%0d pass=%b expected 0000 0 1",
                      if0.mismatch_mask, if0.err_cnt, if0.pass);
    end
    @(negedge clk);
    total++;
    if (if0.done !== 1'b0 || if0.result_valid !== 1'b1 || if0.pass !== 1'b1 || if0.vec_o !== 4'd15) begin
      bad++; $display("FAIL healthy_after got done=%b valid=%b pass=%b vec=%0d expected 0 1 1 15",
                      if0.done, if0.result_valid, if0.pass, if0.vec_o);
    end
  endtask

  task automatic test_faults();
    int cyc;
    nor_stuck0 = 1'b1;
    pulse_start(0);
    total++;
    if (if0.result_valid !== 1'b0 || if0.pass !== 1'b0 || if0.tt_nand !== 16'h0000) begin
      bad++; $display("FAIL start_clears got valid=%b pass=%b tt_nand=%h expected 0 0 0000",
                      if0.result_valid, if0.pass, if0.tt_nand);
    end
    run_to_done(0, 100, cyc);
    total++;
    if (cyc !== 16) begin
      bad++; $display("FAIL nor0_latency got %0d expected 16", cyc);
    end
    total++;
    if (if0.tt_nor !== 16'h0000 || if0.tt_nand !== 16'h3887) begin
      bad++; $display("FAIL nor0_tt got nor=%h nand=%h expected 0000 3887", if0.tt_nor, if0.tt_nand);
    end
    total++;
    if (if0.mismatch_mask !== 16'h3887 || if0.err_cnt !== 5'd7 || if0.pass !== 1'b0) begin
      bad++; $display("FAIL nor0_grade got mask=%h err=%0d pass=%b expected 3887 7 0",
                      if0.mismatch_mask, if0.err_cnt, if0.pass);
    end
    nor_stuck0 = 1'b0;
    flip_nand3 = 1'b1;
    pulse_start(0);
    total++;
    if (if0.mismatch_mask !== 16'h0000 || if0.err_cnt !== 5'd0) begin
      bad++; $display("FAIL restart_clears got mask=%h err=%0d expected 0000 0", if0.mismatch_mask, if0.err_cnt);
    end
    run_to_done(0, 100, cyc);
    total++;
    if (if0.mismatch_mask !== 16'h0008 || if0.err_cnt !== 5'd1 || if0.pass !== 1'b0) begin
      bad++; $display("FAIL flip3_grade got mask=%h err=%0d pass=%b expected 0008 1 0",
                      if0.mismatch_mask, if0.err_cnt, if0.pass);
    end
    total++;
    if (if0.tt_nand !== 16'h388F || if0.tt_nor !== 16'h3887) begin
      bad++; $display("FAIL flip3_tt got nand=%h nor=%h expected 388f 3887", if0.tt_nand, if0.tt_nor);
    end
    flip_nand3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_settle();
    int errs;
    errs = 0;
    pulse_start(1);
    for (int n = 0; n < 64; n++) begin
      if (if3.vec_o !== 4'(n >> 2) || if3.busy !== 1'b1 || if3.done !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL settle_hold got %0d bad cycles expected 0", errs);
    end
    total++;
    if (if3.done !== 1'b1 || if3.vec_o !== 4'd15) begin
      bad++; $display("FAIL settle_latency got done=%b vec=%0d at 64 edges expected 1 15", if3.done, if3.vec_o);
    end
    total++;
    if (if3.tt_nand !== 16'h3887 || if3.tt_nor !== 16'h3887 || if3.mismatch_mask !== 16'h0000 ||
        if3.err_cnt !== 5'd0 || if3.pass !== 1'b1) begin
      bad++; $display("FAIL settle_result got nand=%h nor=%h mask=%h err=%0d pass=%b expected 3887 3887 0000 0 1",
                      if3.tt_nand, if3.tt_nor, if3.mismatch_mask, if3.err_cnt, if3.pass);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int cyc;
    int seen;
    pulse_start(0);
    repeat (5) @(negedge clk);
    total++;
    if (if0.vec_o !== 4'd5) begin
      bad++; $display("FAIL abort_setup got vec=%0d expected 5", if0.vec_o);
    end
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    total++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.result_valid !== 1'b0 || if0.vec_o !== 4'd5) begin
      bad++; $display("FAIL abort_state got busy=%b done=%b valid=%b vec=%0d expected 0 0 0 5",
                      if0.busy, if0.done, if0.result_valid, if0.vec_o);
    end
    total++;
    if (if0.tt_nand !== 16'h0007 || if0.mismatch_mask !== 16'h0000 || if0.err_cnt !== 5'd0) begin
      bad++; $display("FAIL abort_partial got tt_nand=%h mask=%h err=%0d expected 0007 0000 0",
                      if0.tt_nand, if0.mismatch_mask, if0.err_cnt);
    end
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.vec_o !== 4'd5) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL abort_idle got %0d active cycles expected 0", seen);
    end
    if0.start = 1'b1;
    if0.abort = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    if0.abort = 1'b0;
    total++;
    if (if0.busy !== 1'b1 || if0.vec_o !== 4'd0) begin
      bad++; $display("FAIL start_over_abort got busy=%b vec=%0d expected 1 0", if0.busy, if0.vec_o);
    end
    run_to_done(0, 100, cyc);
    total++;
    if (cyc !== 16 || if0.pass !== 1'b1 || if0.tt_nand !== 16'h3887) begin
      bad++; $display("FAIL abort_rerun got cyc=%0d pass=%b tt_nand=%h expected 16 1 3887",
                      cyc, if0.pass, if0.tt_nand);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    pulse_start(0);
    repeat (9) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    total++;
    if (if0.vec_o !== 4'd10 || if0.busy !== 1'b1) begin
      bad++; $display("FAIL restart_ignored got vec=%0d busy=%b expected 10 1", if0.vec_o, if0.busy);
    end
    run_to_done(0, 100, cyc);
    total++;
    if (cyc !== 6 || if0.tt_nand !== 16'h3887 || if0.tt_nor !== 16'h3887 || if0.err_cnt !== 5'd0) begin
      bad++; $display("FAIL restart_sweep got cyc=%0d nand=%h nor=%h err=%0d expected 6 3887 3887 0",
                      cyc, if0.tt_nand, if0.tt_nor, if0.err_cnt);
    end
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    total++;
    if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.result_valid !== 1'b1 || if0.pass !== 1'b1) begin
      bad++; $display("FAIL start_in_done got done=%b busy=%b valid=%b pass=%b expected 0 0 1 1",
                      if0.done, if0.busy, if0.result_valid, if0.pass);
    end
    repeat (2) @(negedge clk);
    total++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin
      bad++; $display("FAIL start_not_queued got busy=%b done=%b expected 0 0", if0.busy, if0.done);
    end
    pulse_start(0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    total++;
    if ({if0.vec_o, if0.busy, if0.done, if0.result_valid, if0.tt_nand, if0.tt_nor,
         if0.mismatch_mask, if0.err_cnt, if0.pass} !== 60'd0) begin
      bad++; $display("FAIL midsweep_reset got vec=%0d busy=%b tt_nand=%h valid=%b expected all zero",
                      if0.vec_o, if0.busy, if0.tt_nand, if0.result_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (if0.busy !== 1'b0 || if0.vec_o !== 4'd0) begin
      bad++; $display("FAIL post_reset_idle got busy=%b vec=%0d expected 0 0", if0.busy, if0.vec_o);
    end
  endtask

  initial begin
    test_reset();
    test_healthy();
    test_faults();
    test_settle();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
